// File: rtl/bpa_pkg.sv
// Shared constants and types for the sequential left-shift accumulator.
package bpa_pkg;

    localparam int BPA_W       = 10;
    localparam int BPA_N_STEPS = 48;
    localparam int BPA_CNT_W   = $clog2(BPA_N_STEPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bpa_state_t;

    typedef logic [BPA_W-1:0] bpa_word_t;

endpackage

// File: rtl/bpa_shl_seq_if.sv
// Run-request / result bundle between a requester and the shift accumulator.
interface bpa_shl_seq_if import bpa_pkg::*; #(
    parameter int W       = BPA_W,
    parameter int N_STEPS = BPA_N_STEPS
);

    logic                 start;
    logic [W-1:0]         seed;
    logic [W*N_STEPS-1:0] amounts;
    logic                 busy;
    logic                 done;
    logic [W-1:0]         a;

    modport master (
        output start,
        output seed,
        output amounts,
        input  busy,
        input  done,
        input  a
    );

    modport slave (
        input  start,
        input  seed,
        input  amounts,
        output busy,
        output done,
        output a
    );

endinterface

// File: rtl/bpa_shl_step.sv
// Combinational saturating left shift: amounts of W or more clear the word.
module bpa_shl_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] amount_i,
    output logic [W-1:0] result_o
);

    // Large amounts are forced to zero explicitly so no tool ever wraps the count.
    always_comb begin
        result_o = '0;
        if (int'(amount_i) >= W) begin
            result_o = '0;
        end else begin
            result_o = value_i << amount_i;
        end
    end

endmodule

// File: rtl/bpa_shl_seq.sv
// Loads a seed and N_STEPS shift amounts, then shifts the accumulator left once per clock.
module bpa_shl_seq import bpa_pkg::*; #(
    parameter int W       = BPA_W,
    parameter int N_STEPS = BPA_N_STEPS
) (
    input  logic         clk,
    input  logic         rst,
    bpa_shl_seq_if.slave bus
);

    localparam int CNT_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);

    bpa_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [W-1:0]         acc_q;
    logic [W*N_STEPS-1:0] amt_q;
    logic [W-1:0]         a_q;
    logic                 busy_q;
    logic                 done_q;

    logic [W-1:0]         cur_amt_s;
    logic [W-1:0]         acc_d;

    // Select the amount for the step the counter points at.
    always_comb begin
        cur_amt_s = amt_q[int'(cnt_q)*W +: W];
    end

    bpa_shl_step #(
        .W (W)
    ) u_step (
        .value_i  (acc_q),
        .amount_i (cur_amt_s),
        .result_o (acc_d)
    );

    // Control FSM with snapshot, step counter and result registers; done is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            amt_q   <= '0;
            a_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        acc_q   <= bus.seed;
                        amt_q   <= bus.amounts;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        a_q     <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.a    = a_q;

endmodule

// File: tb/tb_bpa_shl_seq.sv
// Self-checking bench for bpa_shl_seq: directed scenarios plus randomized runs vs a reference model.
module tb_bpa_shl_seq;

    localparam int W  = 10;
    localparam int NS = 48;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bpa_shl_seq_if #(.W(W), .N_STEPS(NS)) bus ();

    bpa_shl_seq #(.W(W), .N_STEPS(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 48 sequential saturating left shifts on a 10-bit word.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] s, input logic [W*NS-1:0] am);
        int acc;
        int amt;
        acc = int'(s);
        for (int k = 0; k < NS; k++) begin
            amt = int'(am[k*W +: W]);
            if (amt >= W) acc = 0;
            else acc = (acc << amt) % 1024;
        end
        return acc[W-1:0];
    endfunction

    task automatic launch(input logic [W-1:0] s, input logic [W*NS-1:0] am);
        bus.start   = 1'b1;
        bus.seed    = s;
        bus.amounts = am;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [W-1:0] res, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
            if (bus.done === 1'b1) break;
        end
        res = bus.a;
    endtask

    function automatic logic [W*NS-1:0] rand_amounts();
        logic [W*NS-1:0] am;
        am = '0;
        for (int k = 0; k < NS; k++) begin
            if ($urandom_range(0, 7) == 0) am[k*W +: W] = W'($urandom_range(0, 12));
            else if ($urandom_range(0, 99) == 0) am[k*W +: W] = W'($urandom);
            else am[k*W +: W] = '0;
        end
        return am;
    endfunction

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.seed    = '0;
        bus.amounts = '0;
        repeat (3) tick();
        tests_run++;
        if ({bus.busy, bus.done, bus.a} !== {1'b0, 1'b0, 10'h000}) begin
            tests_failed++;
            $display("FAIL reset_state: busy/done/a = %b/%b/%h, required 0/0/000", bus.busy, bus.done, bus.a);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({bus.busy, bus.done, bus.a} !== {1'b0, 1'b0, 10'h000}) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy/done/a = %b/%b/%h, required 0/0/000", bus.busy, bus.done, bus.a);
        end
    endtask

    task automatic directed_case(input string name, input logic [W-1:0] s,
                                 input logic [W*NS-1:0] am, input logic [W-1:0] exp_a);
        int lat;
        logic [W-1:0] res;
        bit busy_ok;
        launch(s, am);
        wait_done(lat, res, busy_ok);
        tests_run++;
        if (lat !== NS || busy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timing: latency %0d busy_ok %0b, required %0d 1", name, lat, busy_ok, NS);
        end
        tests_run++;
        if (res !== exp_a || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_result: a=%h busy=%b, required a=%h busy=0", name, res, bus.busy, exp_a);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b0 || bus.a !== exp_a) begin
            tests_failed++;
            $display("FAIL %s_pulse: done=%b a=%h one cycle later, required done=0 a=%h", name, bus.done, bus.a, exp_a);
        end
    endtask

    task automatic test_directed();
        logic [W*NS-1:0] am;
        am = '0;
        directed_case("zero_amounts", 10'h001, am, 10'h001);
        for (int k = 0; k < 9; k++) am[k*W +: W] = 10'd1;
        directed_case("nine_ones", 10'h001, am, 10'h200);
        am[9*W +: W] = 10'd1;
        directed_case("ten_ones", 10'h001, am, 10'h000);
        am = '0;
        am[47*W +: W] = 10'd3;
        directed_case("last_slice3", 10'h2AB, am, 10'h158);
        am[20*W +: W] = 10'd10;
        directed_case("amount_eq_w", 10'h2AB, am, 10'h000);
        am[20*W +: W] = 10'h3FF;
        directed_case("amount_max", 10'h2AB, am, 10'h000);
    endtask

    task automatic test_snapshot();
        logic [W*NS-1:0] am;
        logic [W-1:0] s, res, exp_a;
        int lat;
        bit busy_ok;
        s  = 10'h003;
        am = '0;
        am[5*W +: W]  = 10'd2;
        am[40*W +: W] = 10'd4;
        exp_a = ref_model(s, am);
        launch(s, am);
        repeat (9) tick();
        bus.seed    = W'($urandom);
        bus.amounts = rand_amounts();
        wait_done(lat, res, busy_ok);
        tests_run++;
        if (lat !== NS - 9 || res !== exp_a) begin
            tests_failed++;
            $display("FAIL snapshot: latency %0d a=%h, required %0d %h", lat, res, NS - 9, exp_a);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [W*NS-1:0] am;
        logic [W-1:0] s, first_a, exp_a;
        int dones;
        s  = 10'h00F;
        am = '0;
        am[0*W +: W] = 10'd1;
        exp_a   = ref_model(s, am);
        dones   = 0;
        first_a = '0;
        launch(s, am);
        for (int i = 1; i <= 110; i++) begin
            if (i == 30) begin
                bus.start = 1'b1;
                bus.seed  = 10'h3FF;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done === 1'b1) begin
                if (dones == 0) first_a = bus.a;
                dones++;
            end
        end
        tests_run++;
        if (dones !== 1 || first_a !== exp_a || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start: dones=%0d a=%h busy=%b, required 1 %h 0", dones, first_a, bus.busy, exp_a);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int bad_a;
        int drain;
        logic [W*NS-1:0] am;
        am = '0;
        am[0*W +: W] = 10'd1;
        bad_a = 0;
        bus.start   = 1'b1;
        bus.seed    = 10'h001;
        bus.amounts = am;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_at.push_back(i);
                if (bus.a !== 10'h002) bad_a++;
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (done_at.size() !== 4 || bad_a !== 0) begin
            tests_failed++;
            $display("FAIL b2b_count: dones=%0d bad_results=%0d, required 4 0", done_at.size(), bad_a);
        end
        for (int j = 0; j < done_at.size(); j++) begin
            tests_run++;
            if (done_at[j] !== 49 + 49 * j) begin
                tests_failed++;
                $display("FAIL b2b_period: done %0d at cycle %0d, required %0d", j, done_at[j], 49 + 49 * j);
            end
        end
        drain = 0;
        while (bus.busy === 1'b1 && drain < 100) begin
            tick();
            drain++;
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: busy=%b after %0d cycles, required 0", bus.busy, drain);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [W*NS-1:0] am;
        int lat;
        int dones;
        logic [W-1:0] res;
        bit busy_ok;
        am = '0;
        am[47*W +: W] = 10'd3;
        launch(10'h2AB, am);
        wait_done(lat, res, busy_ok);
        tests_run++;
        if (res !== 10'h158) begin
            tests_failed++;
            $display("FAIL arst_prerun: a=%h, required 158", res);
        end
        tick();
        launch(10'h001, '0);
        repeat (19) tick();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.a} !== {1'b0, 1'b0, 10'h000}) begin
            tests_failed++;
            $display("FAIL arst_immediate: busy/done/a = %b/%b/%h, required 0/0/000", bus.busy, bus.done, bus.a);
        end
        tick();
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0 || bus.busy !== 1'b0 || bus.a !== 10'h000) begin
            tests_failed++;
            $display("FAIL arst_no_done: dones=%0d busy=%b a=%h, required 0 0 000", dones, bus.busy, bus.a);
        end
        am = '0;
        am[3*W +: W] = 10'd2;
        launch(10'h005, am);
        wait_done(lat, res, busy_ok);
        tests_run++;
        if (lat !== NS || res !== 10'h014 || busy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_rerun: latency %0d a=%h busy_ok %0b, required %0d 014 1", lat, res, busy_ok, NS);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W*NS-1:0] am;
        logic [W-1:0] s, res, exp_a;
        int lat;
        int starts;
        int dones;
        int errs;
        bit busy_ok;
        starts = 0;
        dones  = 0;
        errs   = 0;
        for (int r = 0; r < 1000; r++) begin
            s  = W'($urandom);
            am = rand_amounts();
            exp_a = ref_model(s, am);
            launch(s, am);
            starts++;
            wait_done(lat, res, busy_ok);
            if (bus.done === 1'b1) dones++;
            if (res !== exp_a || lat !== NS || busy_ok !== 1'b1) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_run_%0d: a=%h latency %0d, required a=%h latency %0d", r, res, lat, exp_a, NS);
            end
            tick();
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL random_results: %0d mismatching runs, required 0", errs);
        end
        tests_run++;
        if (dones !== starts) begin
            tests_failed++;
            $display("FAIL random_done_count: dones=%0d, required %0d", dones, starts);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_snapshot();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
